vp_controller: RTL and testbench

VP_CONTROLLER -- requirements
Module: vp_controller

---
 rtl/vp_controller.sv | 177 +++++++++++++++++
 tb/tb_vp_controller.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/vp_controller.sv
// Load value-prediction controller: per-PC 2-bit confidence table, speculation
// window with timeout, and checkpoint/flush sequencing for misprediction recovery.
module vp_controller #(
  parameter int INDEX_WIDTH     = 6,
  parameter int THRESH          = 2,
  parameter int MAX_SPEC_CYCLES = 32,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  input  logic [ADDR_WIDTH-1:0] miss_pc,
  input  logic                  dc_resp_valid,
  input  logic                  vp_correct,
  input  logic                  vp_mismatch,
  input  logic                  recover_done,
  output logic                  vp_en,
  output logic                  ckpt_save,
  output logic                  ckpt_restore,
  output logic                  flush,
  output logic                  mem_stall,
  output logic                  spec_active,
  output logic [31:0]           pred_cnt,
  output logic [31:0]           mispred_cnt
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;
  localparam int TW      = (MAX_SPEC_CYCLES > 1) ? $clog2(MAX_SPEC_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_NOPRED, SPEC, RECOVER} state_e;

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   sticky_q, sticky_d;
  logic                   pend_q, pend_d;
  logic [31:0]            pred_cnt_q, mispred_cnt_q;
  logic [1:0]             conf_q [ENTRIES];

  logic [INDEX_WIDTH-1:0] rd_idx;
  logic [1:0]             conf_rd, conf_cur, conf_inc, conf_dec, conf_wdata;
  logic                   conf_we, hit, timeout, rec_done, rec_data_ok;
  logic                   vp_en_c, save_c, restore_c, flush_c, stall_c, spec_c;
  logic                   pred_inc, mis_inc;
  logic                   unused_pc_bits;

  assign rd_idx   = miss_pc[INDEX_WIDTH+1:2];
  assign conf_rd  = conf_q[rd_idx];
  assign conf_cur = conf_q[idx_q];
  assign conf_inc = (conf_cur == 2'd3) ? 2'd3 : conf_cur + 2'd1;
  assign conf_dec = (conf_cur == 2'd0) ? 2'd0 : conf_cur - 2'd1;
  assign hit      = 32'(conf_rd) >= 32'(THRESH);
  assign timeout  = timer_q == TW'(MAX_SPEC_CYCLES - 1);
  // Recovery may finish before or after the outstanding fill; either order is fine.
  assign rec_done    = sticky_q | recover_done;
  assign rec_data_ok = ~pend_q | dc_resp_valid;

  assign unused_pc_bits = ^{miss_pc[ADDR_WIDTH-1:INDEX_WIDTH+2], miss_pc[1:0]};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    sticky_d   = sticky_q;
    pend_d     = pend_q;
    conf_we    = 1'b0;
    conf_wdata = conf_cur;
    vp_en_c    = 1'b0;
    save_c     = 1'b0;
    restore_c  = 1'b0;
    flush_c    = 1'b0;
    stall_c    = 1'b0;
    spec_c     = 1'b0;
    pred_inc   = 1'b0;
    mis_inc    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (miss_valid) begin
          idx_d = rd_idx;
          if (hit) begin
            state_d  = SPEC;
            vp_en_c  = 1'b1;
            save_c   = 1'b1;
            pred_inc = 1'b1;
            timer_d  = '0;
          end else begin
            state_d = WAIT_NOPRED;
          end
        end
      end
      WAIT_NOPRED: begin
        stall_c = 1'b1;
        if (dc_resp_valid) begin
          conf_we    = 1'b1;
          conf_wdata = conf_inc;
          state_d    = IDLE;
        end
      end
      SPEC: begin
        spec_c  = 1'b1;
        timer_d = timer_q + TW'(1);
        // Mismatch outranks correct, and any resolution outranks the timeout.
        if (vp_mismatch) begin
          flush_c    = 1'b1;
          restore_c  = 1'b1;
          mis_inc    = 1'b1;
          conf_we    = 1'b1;
          conf_wdata = 2'd0;
          pend_d     = 1'b0;
          state_d    = RECOVER;
        end else if (vp_correct) begin
          conf_we    = 1'b1;
          conf_wdata = conf_inc;
          state_d    = IDLE;
        end else if (timeout) begin
          flush_c    = 1'b1;
          restore_c  = 1'b1;
          mis_inc    = 1'b1;
          conf_we    = 1'b1;
          conf_wdata = conf_dec;
          pend_d     = 1'b1;
          state_d    = RECOVER;
        end
      end
      RECOVER: begin
        stall_c = 1'b1;
        if (recover_done)  sticky_d = 1'b1;
        if (dc_resp_valid) pend_d   = 1'b0;
        if (rec_done && rec_data_ok) begin
          sticky_d = 1'b0;
          pend_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      timer_q       <= '0;
      sticky_q      <= 1'b0;
      pend_q        <= 1'b0;
      pred_cnt_q    <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      sticky_q <= sticky_d;
      pend_q   <= pend_d;
      if (pred_inc) pred_cnt_q    <= pred_cnt_q + 32'd1;
      if (mis_inc)  mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < ENTRIES; e++) conf_q[e] <= 2'd0;
    end else if (conf_we) begin
      conf_q[idx_q] <= conf_wdata;
    end
  end

  // Outputs are masked while reset is asserted so no stale pulse escapes.
  assign vp_en        = vp_en_c   & ~rst;
  assign ckpt_save    = save_c    & ~rst;
  assign ckpt_restore = restore_c & ~rst;
  assign flush        = flush_c   & ~rst;
  assign mem_stall    = stall_c   & ~rst;
  assign spec_active  = spec_c    & ~rst;
  assign pred_cnt     = rst ? 32'd0 : pred_cnt_q;
  assign mispred_cnt  = rst ? 32'd0 : mispred_cnt_q;

endmodule

// File: tb/tb_vp_controller.sv
// Vector-table bench for vp_controller: per-cycle stimulus with expected
// outputs queued on drive and checked half a cycle later.
module tb_vp_controller;

  logic        clk = 1'b0;
  logic        rst, miss_valid, dc_resp_valid, vp_correct, vp_mismatch, recover_done;
  logic [31:0] miss_pc;
  logic        vp_en, ckpt_save, ckpt_restore, flush, mem_stall, spec_active;
  logic [31:0] pred_cnt, mispred_cnt;

  vp_controller #(.INDEX_WIDTH(6), .THRESH(2), .MAX_SPEC_CYCLES(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_pc(miss_pc),
    .dc_resp_valid(dc_resp_valid), .vp_correct(vp_correct), .vp_mismatch(vp_mismatch),
    .recover_done(recover_done), .vp_en(vp_en), .ckpt_save(ckpt_save),
    .ckpt_restore(ckpt_restore), .flush(flush), .mem_stall(mem_stall),
    .spec_active(spec_active), .pred_cnt(pred_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  // flag order: {vp_en, ckpt_save, ckpt_restore, flush, mem_stall, spec_active}
  localparam logic [5:0] N  = 6'b000000;
  localparam logic [5:0] VS = 6'b110000;
  localparam logic [5:0] FR = 6'b001101;
  localparam logic [5:0] MS = 6'b000010;
  localparam logic [5:0] SA = 6'b000001;

  typedef struct {
    string       name;
    logic        r, mv, dr, vc, vm, rd;
    logic [31:0] pc;
    logic [5:0]  f;
    logic [31:0] ep, em;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic [31:0] ep = 0, em = 0;

  task automatic add(input string nm, input logic r, input logic mv, input logic [31:0] pc,
                     input logic dr, input logic vc, input logic vm, input logic rd,
                     input logic [5:0] f);
    vec_t v;
    if (r) begin ep = 0; em = 0; end
    v.name = nm; v.r = r; v.mv = mv; v.pc = pc; v.dr = dr; v.vc = vc; v.vm = vm;
    v.rd = rd; v.f = f; v.ep = ep; v.em = em;
    vecs.push_back(v);
    if (f[5]) ep = ep + 1;
    if (f[2]) em = em + 1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    logic [5:0] got;
    rst = 1'b1; miss_valid = 0; miss_pc = 0; dc_resp_valid = 0;
    vp_correct = 0; vp_mismatch = 0; recover_done = 0;

    // reset, then train pc 0x40: 0 -> 1 -> 2, third miss predicts
    add("reset",        1,0,'h40,0,0,0,0,N);
    add("idle",         0,0,'h40,0,0,0,0,N);
    add("miss0",        0,1,'h40,0,0,0,0,N);
    add("wait0",        0,0,'h40,0,0,0,0,MS);
    add("resp0",        0,0,'h40,1,0,0,0,MS);
    add("miss1",        0,1,'h40,0,0,0,0,N);
    add("resp1",        0,0,'h40,1,0,0,0,MS);
    add("miss2_pred",   0,1,'h40,0,0,0,0,VS);
    add("spec",         0,0,'h40,0,0,0,0,SA);
    add("spec_ok",      0,0,'h40,0,1,0,0,SA);
    add("idle2",        0,0,'h40,0,0,0,0,N);
    // conf 3, five SPEC cycles with correct on the fifth; a miss mid-SPEC is ignored
    add("miss3",        0,1,'h40,0,0,0,0,VS);
    add("spec5_a",      0,0,'h40,0,0,0,0,SA);
    add("spec5_missig", 0,1,'h40,0,0,0,0,SA);
    add("spec5_c",      0,0,'h40,1,0,0,0,SA);
    add("spec5_d",      0,0,'h40,0,0,0,0,SA);
    add("spec5_ok",     0,0,'h40,0,1,0,0,SA);
    add("idle3",        0,0,'h40,0,0,0,0,N);
    // mismatch, recover_done four cycles later
    add("miss4",        0,1,'h40,0,0,0,0,VS);
    add("mismatch",     0,0,'h40,0,0,1,0,FR);
    for (int i = 0; i < 3; i++) add("rec",  0,0,'h40,0,0,0,0,MS);
    add("rec_done",     0,0,'h40,0,0,0,1,MS);
    add("after_rec",    0,0,'h40,0,0,0,0,N);
    add("miss_conf0",   0,1,'h40,0,0,0,0,N);
    add("resp_c0",      0,0,'h40,1,0,0,0,MS);
    add("idle_ignored", 0,0,'h40,1,1,1,1,N);
    add("other_pc",     0,1,'h44,0,0,0,0,N);
    add("resp44",       0,0,'h44,1,0,0,0,MS);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      rst = vecs[i].r; miss_valid = vecs[i].mv; miss_pc = vecs[i].pc;
      dc_resp_valid = vecs[i].dr; vp_correct = vecs[i].vc; vp_mismatch = vecs[i].vm;
      recover_done = vecs[i].rd;
      sb.push_back(vecs[i]);
      @(negedge clk);
      e = sb.pop_front();
      got = {vp_en, ckpt_save, ckpt_restore, flush, mem_stall, spec_active};
      check({e.name, ".flags"}, 32'(got), 32'(e.f));
      check({e.name, ".pred"}, pred_cnt, e.ep);
      check({e.name, ".mispred"}, mispred_cnt, e.em);
    end
    vecs.delete();

    // pc 0x40 at conf 1: train to 3, then a full timeout window
    add("t_miss",       0,1,'h40,0,0,0,0,N);
    add("t_resp",       0,0,'h40,1,0,0,0,MS);
    add("t_pred",       0,1,'h40,0,0,0,0,VS);
    add("t_ok",         0,0,'h40,0,1,0,0,SA);
    add("to_miss",      0,1,'h40,0,0,0,0,VS);
    for (int k = 1; k < 32; k++) add("to_spec", 0,0,'h40,0,0,0,0,SA);
    add("to_flush",     0,0,'h40,0,0,0,0,FR);
    add("tr1",          0,0,'h40,0,0,0,0,MS);
    add("tr2_done",     0,0,'h40,0,0,0,1,MS);
    for (int k = 0; k < 3; k++) add("tr_wait", 0,0,'h40,0,0,0,0,MS);
    add("tr6_resp",     0,0,'h40,1,0,0,0,MS);
    add("tr_idle",      0,0,'h40,0,0,0,0,N);
    // conf now 2: still predicts; correct+mismatch together takes the mismatch path
    add("c2_miss",      0,1,'h40,0,0,0,0,VS);
    add("both",         0,0,'h40,0,1,1,0,FR);
    add("rec_b",        0,0,'h40,0,0,0,0,MS);
    add("rst_in_rec",   1,0,'h40,0,0,0,1,N);
    add("post_rst",     0,0,'h40,0,0,0,0,N);
    // resolution on the timeout cycle wins
    add("tie_m0",       0,1,'h40,0,0,0,0,N);
    add("tie_r0",       0,0,'h40,1,0,0,0,MS);
    add("tie_m1",       0,1,'h40,0,0,0,0,N);
    add("tie_r1",       0,0,'h40,1,0,0,0,MS);
    add("tie_pred",     0,1,'h40,0,0,0,0,VS);
    for (int k = 1; k < 32; k++) add("tie_spec", 0,0,'h40,0,0,0,0,SA);
    add("tie_ok",       0,0,'h40,0,1,0,0,SA);
    add("tie_idle",     0,0,'h40,0,0,0,0,N);
    add("tie_pred2",    0,1,'h40,0,0,0,0,VS);
    add("tie_spec2",    0,0,'h40,0,0,0,0,SA);
    add("rst_in_spec",  1,0,'h40,0,0,1,0,N);
    add("post_rst2",    0,0,'h40,0,0,0,0,N);
    add("post_miss",    0,1,'h40,0,0,0,0,N);
    add("post_wait",    0,0,'h40,0,0,0,0,MS);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      rst = vecs[i].r; miss_valid = vecs[i].mv; miss_pc = vecs[i].pc;
      dc_resp_valid = vecs[i].dr; vp_correct = vecs[i].vc; vp_mismatch = vecs[i].vm;
      recover_done = vecs[i].rd;
      sb.push_back(vecs[i]);
      @(negedge clk);
      e = sb.pop_front();
      got = {vp_en, ckpt_save, ckpt_restore, flush, mem_stall, spec_active};
      check({e.name, ".flags"}, 32'(got), 32'(e.f));
      check({e.name, ".pred"}, pred_cnt, e.ep);
      check({e.name, ".mispred"}, mispred_cnt, e.em);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
